sigmoid_pipe: RTL and testbench

- Parametrised, pipelined piecewise-linear activation unit. Successor to the single-register Q8.8 sigmoid approximator.
- Accepts signed fixed-point samples on a valid/ready stream and returns sigmoid approximations after a 3-stage pipeline.
- Optional build adds a tanh mode. A user tag travels with each sample so downstream logic can match results.
- Sits between the input-word assembly logic and the output pin registers of the top-level.

---
 rtl/sigmoid_pipe.sv | 203 ++++++++++++++++++++
 tb/tb_sigmoid_pipe.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sigmoid_pipe.sv
// Purpose : pipelined piecewise-linear sigmoid (optional tanh) on a signed Q(IW).(FW) stream, tag carried alongside.
// Latency : 3 cycles from accept to out_valid; one sample per cycle with out_ready held high.
// Backpr. : stall-aware valid/ready chain; holds up to 3 samples, in_ready drops only when all stages are full and out_ready is low.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   in_valid/in_ready            input handshake; in_data signed Q(IW).(FW), in_tag user tag
//   mode                         0 = sigmoid, 1 = tanh (honoured only when SIGMOID_PIPE_TANH_EN is defined)
//   out_valid/out_ready          output handshake; out_data Q(IW).(FW) result, out_tag matching tag
//
// Build option: define SIGMOID_PIPE_TANH_EN to build the tanh path. Without it, mode
// is ignored and every result is a sigmoid approximation.
//
// Approximation: with a = |x|, ip = integer part, fr = fraction,
//   t = (HALF + fr/4) >> ip   (zero once ip exceeds FW)
//   sigmoid(x) = x < 0 ? t : ONE - t
//   tanh(x)    = sigmoid-style segment evaluated on 2|x|, mapped to ONE - 2t (sign-mirrored).
module sigmoid_pipe #(
    parameter int IW   = 8,
    parameter int FW   = 8,
    parameter int TAGW = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IW+FW-1:0]    in_data,
    input  logic [TAGW-1:0]     in_tag,
    input  logic                mode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [IW+FW-1:0]    out_data,
    output logic [TAGW-1:0]     out_tag
);

    localparam int W = IW + FW;

    localparam logic [W-1:0] ONE      = W'(1) << FW;
    localparam logic [W-1:0] HALF     = W'(1) << (FW - 1);
    localparam logic [W-1:0] MAX_POS  = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    // FW widened so the shift-out test works for any IW (including IW smaller than log2(FW)).
    localparam logic [IW+31:0] FW_EXT = (IW + 32)'(FW);

    // Stage 1: sign and saturated magnitude.
    typedef struct packed {
        logic            sgn;
        logic [TAGW-1:0] tag;
        logic [W-1:0]    mag;
    } st1_t;

    // Stage 2: sign and segment value t.
    typedef struct packed {
        logic            sgn;
        logic [TAGW-1:0] tag;
        logic [W-1:0]    t;
    } st2_t;

    logic v1, v2, v3;
    st1_t st1;
    st2_t st2;

`ifdef SIGMOID_PIPE_TANH_EN
    logic m1, m2;
`else
    logic unused_mode;
    assign unused_mode = mode;
`endif

    // ------------------------------------------------------------------
    // Load enables. A stage loads when it is empty or its contents move
    // on this cycle, so bubbles collapse and a full pipe can accept and
    // emit on the same edge.
    // ------------------------------------------------------------------
    logic adv2, adv3;

    assign adv3      = !v3 || out_ready;
    assign adv2      = !v2 || adv3;
    assign in_ready  = !v1 || adv2;
    assign out_valid = v3;

    // ------------------------------------------------------------------
    // Stage 1: absolute value. The most negative input has no positive
    // counterpart and saturates to the largest positive magnitude.
    // ------------------------------------------------------------------
    logic [W-1:0] in_neg;
    logic [W-1:0] in_abs;

    always_comb begin
        in_neg = -in_data;
        if (!in_data[W-1]) begin
            in_abs = in_data;
        end else if (in_data == MOST_NEG) begin
            in_abs = MAX_POS;
        end else begin
            in_abs = in_neg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1  <= 1'b0;
            st1 <= '0;
`ifdef SIGMOID_PIPE_TANH_EN
            m1  <= 1'b0;
`endif
        end else if (in_ready) begin
            v1 <= in_valid;
            if (in_valid) begin
                st1.sgn <= in_data[W-1];
                st1.tag <= in_tag;
                st1.mag <= in_abs;
`ifdef SIGMOID_PIPE_TANH_EN
                m1      <= mode;
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: segment lookup. tanh(x) = 2*sigmoid(2x) - 1, so the tanh
    // path doubles the magnitude first (saturating; mag[W-1] is always 0
    // so overflow shows up as mag[W-2]).
    // ------------------------------------------------------------------
    logic [W-1:0]  seg_a;
    logic [IW-1:0] seg_ip;
    logic [FW-1:0] seg_fr;
    logic [W-1:0]  seg_t;

    always_comb begin
        seg_a = st1.mag;
`ifdef SIGMOID_PIPE_TANH_EN
        if (m1) begin
            seg_a = st1.mag[W-2] ? MAX_POS : {st1.mag[W-2:0], 1'b0};
        end
`endif
        seg_ip = seg_a[W-1:FW];
        seg_fr = seg_a[FW-1:0];
        // Beyond FW integer steps the segment has shifted out entirely.
        if ((IW + 32)'(seg_ip) > FW_EXT) begin
            seg_t = '0;
        end else begin
            seg_t = (HALF + W'(seg_fr >> 2)) >> seg_ip;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2  <= 1'b0;
            st2 <= '0;
`ifdef SIGMOID_PIPE_TANH_EN
            m2  <= 1'b0;
`endif
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                st2.sgn <= st1.sgn;
                st2.tag <= st1.tag;
                st2.t   <= seg_t;
`ifdef SIGMOID_PIPE_TANH_EN
                m2      <= m1;
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: mirror around the midpoint by sign. Sigmoid lands in
    // 0..ONE; tanh lands in -ONE..ONE as two's complement (wraps in W bits).
    // ------------------------------------------------------------------
    logic [W-1:0] res;
`ifdef SIGMOID_PIPE_TANH_EN
    logic [W-1:0] t_x2;
`endif

    always_comb begin
        res = st2.sgn ? st2.t : (ONE - st2.t);
`ifdef SIGMOID_PIPE_TANH_EN
        t_x2 = {st2.t[W-2:0], 1'b0};
        if (m2) begin
            res = st2.sgn ? (t_x2 - ONE) : (ONE - t_x2);
        end
`endif
    end

    // Output registers only change when a new sample moves in, so data
    // and tag hold stable while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3       <= 1'b0;
            out_data <= '0;
            out_tag  <= '0;
        end else if (adv3) begin
            v3 <= v2;
            if (v2) begin
                out_data <= res;
                out_tag  <= st2.tag;
            end
        end
    end

endmodule

// File: tb/tb_sigmoid_pipe.sv
module tb_sigmoid_pipe;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [3:0]   in_tag;
    logic         mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [3:0]   out_tag;

    // Expected result travelling with the sample currently driven.
    logic [W-1:0] in_exp;
    logic [W+3:0] exp_q[$];
    logic [W+3:0] mon_e;

    int n_tests   = 0;
    int n_fail    = 0;
    int stall_cnt = 0;

    always #5 clk = ~clk;

    sigmoid_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every accepted sample queues its hand-computed result;
    // every emitted result must match the oldest one, in order.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("stale_out", 32'(out_valid), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_data", 32'(out_data), 32'(mon_e[W+3:4]));
                    check("out_tag", 32'(out_tag), 32'(mon_e[3:0]));
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({in_exp, in_tag});
            end
        end
    end

    // Present one sample, hold it until accepted; returns just after the accepting edge.
    task automatic send(input logic [W-1:0] d, input logic [3:0] t, input logic m, input logic [W-1:0] e);
        logic acc;
        int   waits;
        waits    = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_tag   = t;
        mode     = m;
        in_exp   = e;
        acc      = 1'b0;
        while (!acc && waits < 50) begin
            @(negedge clk);
            acc = in_ready;
            if (!acc) begin
                waits++;
                @(posedge clk);
                #1;
            end
        end
        if (!acc) check("send_timeout", 32'(acc), 32'd1);
        stall_cnt += waits;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // Directed vectors (FW=8). t = (0x80 + fr/4) >> ip, zero when ip > 8.
    //  0x0000: t=0x80           -> 0x100-0x80 = 0x080
    //  0x0100: ip=1, t=0x40     -> 0x0C0
    //  0xFF00: neg, t=0x40      -> 0x040
    //  0x0280: ip=2, t=0xA0>>2=0x28 -> 0x0D8
    //  0x8000: |x| sat 0x7FFF, ip=0x7F -> t=0, neg -> 0x000
    //  0x7FFF: ip=0x7F -> t=0   -> 0x100
    //  0x0900: ip=9 -> t=0      -> 0x100
    //  0xF700: neg, ip=9 -> t=0 -> 0x000
    logic [W-1:0] v_in  [8] = '{16'h0000, 16'h0100, 16'hFF00, 16'h0280,
                                16'h8000, 16'h7FFF, 16'h0900, 16'hF700};
    logic [W-1:0] v_exp [8] = '{16'h0080, 16'h00C0, 16'h0040, 16'h00D8,
                                16'h0000, 16'h0100, 16'h0100, 16'h0000};

    logic [W-1:0] bp_in  [5] = '{16'h0000, 16'h0100, 16'hFF00, 16'h0280, 16'h0900};
    logic [W-1:0] bp_exp [5] = '{16'h0080, 16'h00C0, 16'h0040, 16'h00D8, 16'h0100};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int           k;
        logic         held_set;
        logic [W-1:0] held;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_tag    = '0;
        mode      = 1'b0;
        out_ready = 1'b1;
        in_exp    = '0;

        // Reset state
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency: lone sample shows up in the third cycle after the accepting edge.
        send(16'h0100, 4'hA, 1'b0, 16'h00C0);
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_c1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_c2", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_c3", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        wait_drain("lat_drain");

        // Back-to-back stream incl. saturation / shift-out, full throughput.
        stall_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            send(v_in[i], 4'(i + 1), 1'b0, v_exp[i]);
        end
        in_valid = 1'b0;
        check("stream_stalls", 32'(stall_cnt), 32'd0);
        wait_drain("stream_drain");

        // Back-pressure: out_ready low for 8 cycles while 5 samples are offered.
        out_ready = 1'b0;
        k         = 0;
        held_set  = 1'b0;
        held      = '0;
        for (int c = 0; c < 8; c++) begin
            if (k < 5) begin
                in_valid = 1'b1;
                in_data  = bp_in[k];
                in_tag   = 4'(k + 8);
                in_exp   = bp_exp[k];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (k >= 3) check("bp_in_ready_low", 32'(in_ready), 32'd0);
            if (out_valid) begin
                if (!held_set) begin
                    held     = out_data;
                    held_set = 1'b1;
                end else begin
                    check("bp_hold_data", 32'(out_data), 32'(held));
                end
            end
            if (in_valid && in_ready) k++;
            @(posedge clk);
            #1;
        end
        check("bp_accepts", 32'(k), 32'd3);
        check("bp_first_held", 32'(held), 32'h0080);
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (k < 5) begin
                in_valid = 1'b1;
                in_data  = bp_in[k];
                in_tag   = 4'(k + 8);
                in_exp   = bp_exp[k];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            check("bp_no_gap", 32'(out_valid), 32'd1);
            if (in_valid && in_ready) k++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("bp_all_accepted", 32'(k), 32'd5);
        wait_drain("bp_drain");

        // Reset mid-stream with three samples in flight.
        send(16'h0000, 4'h1, 1'b0, 16'h0080);
        send(16'h0100, 4'h2, 1'b0, 16'h00C0);
        send(16'hFF00, 4'h3, 1'b0, 16'h0040);
        in_valid = 1'b0;
        check("mid_pre_valid", 32'(out_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_data", 32'(out_data), 32'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rel_in_ready", 32'(in_ready), 32'd1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("mid_no_stale", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send(16'h0280, 4'h5, 1'b0, 16'h00D8);
        in_valid = 1'b0;
        wait_drain("mid_after_drain");

`ifdef SIGMOID_PIPE_TANH_EN
        // tanh, interleaved with sigmoid per sample.
        //  0x0080: 2|x|=0x100, t=0x40 -> 0x100-0x80 = 0x0080
        //  0xFF80: same t, negative  -> 0x80-0x100 = 0xFF80
        //  0x0000: t=0x80            -> 0x0000
        //  0x0000 sigmoid            -> 0x0080
        send(16'h0080, 4'h1, 1'b1, 16'h0080);
        send(16'hFF80, 4'h2, 1'b1, 16'hFF80);
        send(16'h0000, 4'h3, 1'b1, 16'h0000);
        send(16'h0000, 4'h4, 1'b0, 16'h0080);
        send(16'h0000, 4'h5, 1'b1, 16'h0000);
`else
        // mode is ignored: sigmoid result regardless.
        send(16'h0100, 4'h6, 1'b1, 16'h00C0);
        send(16'h0000, 4'h7, 1'b1, 16'h0080);
`endif
        in_valid = 1'b0;
        mode     = 1'b0;
        wait_drain("mode_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
